// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter slice:
// default widths, nibble-adjust constants and the FSM state type.
package bcd_pkg;

    localparam int BCD_DIGITS = 3;
    localparam int BCD_BIN_W  = 10;
    localparam int BCD_OUT_W  = 8;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;
    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_e;

    function automatic logic nibble_bad(input logic [3:0] nib);
        return nib > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Reverse double-dabble correction for one BCD nibble after a right shift:
// a bit worth 8 arriving from the next decade is really worth 5.
module bcd_nibble_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= BCD_ADJ_THRESH) ? (nib_i - BCD_ADJ_SUB) : nib_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter, one shift per clock,
// with start/done handshake, digit check and 8-bit saturated score.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = BCD_DIGITS,
    parameter int BIN_W  = BCD_BIN_W,
    parameter int OUT_W  = BCD_OUT_W
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    result,
    output logic [OUT_W-1:0]    score,
    output logic                overflow,
    output logic                digit_err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [BIN_W-1:0] SCORE_MAX = BIN_W'((2 ** OUT_W) - 1);
    localparam logic [CNT_W-1:0] LAST_IT   = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e state_q, state_d;

    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BIN_W-1:0] result_q, result_d;
    logic [OUT_W-1:0] score_q, score_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [BCD_W-1:0] bcd_sh;
    logic [BCD_W-1:0] bcd_adj;
    logic [BIN_W-1:0] bin_sh;
    logic             bad_digit;
    logic             last_iter;
    logic             sh_ovf;

    assign bcd_sh    = {1'b0, bcd_q[BCD_W-1:1]};
    assign bin_sh    = {bcd_q[0], bin_q[BIN_W-1:1]};
    assign last_iter = (cnt_q == LAST_IT);
    assign sh_ovf    = (bin_sh > SCORE_MAX);

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .nib_i (bcd_sh[4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (nibble_bad(bcd_in[4*i +: 4])) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        score_d  = score_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        // Reject without shifting; residue stays clean.
                        state_d  = FINISH;
                        bcd_d    = '0;
                        done_d   = 1'b1;
                        result_d = '0;
                        score_d  = '0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        bcd_d   = bcd_in;
                        bin_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                    end
                end
            end
            SHIFT: begin
                bin_d = bin_sh;
                cnt_d = cnt_q + CNT_ONE;
                if (last_iter) begin
                    state_d  = FINISH;
                    bcd_d    = bcd_sh;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = bin_sh;
                    ovf_d    = sh_ovf;
                    score_d  = sh_ovf ? {OUT_W{1'b1}} : bin_sh[OUT_W-1:0];
                end else begin
                    bcd_d = bcd_adj;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            score_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            score_q  <= score_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Every decade must have drained into the binary register by FINISH.
    a_residue_zero : assert property (
        @(posedge clock) disable iff (!resetn)
        (state_q == FINISH) |-> (bcd_q == '0)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign score     = score_q;
    assign overflow  = ovf_q;
    assign digit_err = err_q;

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential 3-digit BCD-to-binary converter. It is the inverse of the score-to-decimal digit path and turns packed decimal digits (hundreds, tens, ones nibbles) back into a binary value. Typical sources are switch-entered target scores, the high-score register, and digit-wise counters. It uses a reverse double-dabble shifter, one bit per clock, with a start/done handshake, and flags invalid digits and values that exceed 8 bits.

## Interface
- DIGITS, 3, number of packed BCD nibbles in the input
- BIN_W, 10, full result width; must satisfy 2^BIN_W > 10^DIGITS − 1
- OUT_W, 8, width of the saturated score output
- clock  input  1  system clock; all state updates on the rising edge
- resetn  input  1  asynchronous, active-low reset
- start  input  1  request a conversion; sampled only when busy=0
- bcd_in  input  4*DIGITS  packed BCD, [11:8] hundreds, [7:4] tens, [3:0] ones
- busy  output  1  conversion in progress
- done  output  1  single-cycle pulse; result, score, overflow and digit_err are valid while it is high and remain held until the next accepted start
- result  output  BIN_W  full binary value
- score  output  OUT_W  result saturated to 2^OUT_W − 1
- overflow  output  1  result > 2^OUT_W − 1
- digit_err  output  1  some input nibble > 9

## Operation
- Reset values:
  - State is IDLE.
  - busy, done, overflow and digit_err are 0.
  - result and score are 0.
  - Internal shift registers are cleared.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE with start=1:
  - Any nibble > 9: go to FINISH. result and score are set to 0, digit_err=1, overflow=0.
  - Otherwise: load bcd_in into the BCD register, clear the binary register, clear the iteration counter, clear digit_err, go to SHIFT.
- SHIFT, once per cycle:
  - Shift the concatenation {bcd_reg, bin_reg} right by one bit. The BCD LSB enters the binary MSB.
  - On iterations 1..BIN_W−1, adjust every BCD nibble that is ≥ 8 by subtracting 3.
  - On iteration BIN_W, apply no adjustment and go to FINISH.
- FINISH (exactly one cycle):
  - done=1 and busy=0.
  - result = bin_reg.
  - score = min(bin_reg, 2^OUT_W − 1).
  - overflow set accordingly.
  - Return to IDLE.
- In FINISH, the bcd_reg residue must be zero. A nonzero residue is an internal-error assertion for verification; it is not a port.
- start while busy=1 is ignored and has no queueing.
- start in the FINISH cycle is ignored. A new start is accepted from the following IDLE cycle onward.
- Asynchronous reset mid-conversion aborts immediately. All outputs return to their reset values and no done pulse is produced.
- Width rules:
  - Nibble adjustment is 4-bit unsigned; no borrow is possible because only nibbles ≥ 8 are adjusted.
  - The iteration counter is ceil(log2(BIN_W+1)) bits.

## Timing
- Start is accepted at edge E0.
- Valid input: busy=1 after E0. Shifts occur at edges E1..E10. FINISH is entered after E10. done=1 in the cycle after E10. busy falls after E10.
  - Start-to-done latency is BIN_W cycles (10 at defaults).
  - Minimum spacing between accepted starts is BIN_W+2 cycles.
- Invalid digit: FINISH is entered after E0, so done=1 in the cycle immediately after E0 (1-cycle latency). busy stays 0.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `bcd_pkg` holds:
  - DIGITS, BIN_W and OUT_W defaults
  - the BCD_ADJ_THRESH=8 and BCD_ADJ_SUB=3 constants
  - the FSM state enum {IDLE, SHIFT, FINISH}
- Sub-module `bcd_nibble_adjust`: 4-bit combinational, out = in ≥ 8 ? in − 3 : in. Instantiated DIGITS times by generate.
- The top level contains the FSM, the {bcd_reg, bin_reg} shifter, the iteration counter, the digit-validity check, and the output registers.

## Test plan
- bcd_in=0x251, start for 1 cycle → done exactly 10 cycles after acceptance; result=251, score=251, overflow=0, digit_err=0; busy high for 10 cycles.
- bcd_in=0x999 → result=999, score=255, overflow=1. Also bcd_in=0x256 → result=256, score=255, overflow=1. Also bcd_in=0x255 → score=255, overflow=0.
- bcd_in=0x0A5 → done 1 cycle after start; digit_err=1, result=0, score=0, overflow=0, busy never asserted.
- Accepted start with 0x123, then start held high with bcd_in=0x456 throughout → first done gives result=123; the next conversion starts in the first IDLE cycle after FINISH and gives result=456.
- resetn pulled low at cycle 5 of a 0x789 conversion → all outputs 0 asynchronously and no done. After release, start with 0x007 → result=7 after 10 cycles.
- Exhaustive sweep of 0x000..0x999 over all valid BCD values → result equals the decimal value, score equals min(value, 255), and the BCD residue is zero at every FINISH.
